// File: rtl/morse_pkg.sv
// Shared Morse display types: default character width, blank glyph code,
// per-cycle line-buffer operation and character-slot load selection.
package morse_pkg;

    localparam int         CHAR_W_DEF = 8;
    localparam logic [7:0] BLANK_CHAR = 8'hFF;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_CLR     = 3'd1,
        OP_PUSH    = 3'd2,
        OP_POP     = 3'd3,
        OP_REPLACE = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LEFT  = 2'd1,
        SEL_RIGHT = 2'd2,
        SEL_VALUE = 2'd3
    } slot_sel_t;

    // Slot k takes the newer neighbour on push, the older one on pop, and a
    // direct value when it is slot 0 being written or the whole line is cleared.
    function automatic slot_sel_t slot_sel(input op_t op, input logic is_newest);
        slot_sel_t sel;
        case (op)
            OP_CLR:     sel = SEL_VALUE;
            OP_PUSH:    sel = is_newest ? SEL_VALUE : SEL_LEFT;
            OP_POP:     sel = SEL_RIGHT;
            OP_REPLACE: sel = is_newest ? SEL_VALUE : SEL_HOLD;
            default:    sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/char_line_buffer_if.sv
// Push/pop/clear handshake and flat display bus of the character line buffer.
// The master drives requests; the slave (the buffer) returns status and the line.
interface char_line_buffer_if #(
    parameter int CHAR_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    clr;
    logic                    push_valid;
    logic [CHAR_W-1:0]       push_char;
    logic                    push_ready;
    logic                    pop_valid;
    logic                    pop_ready;
    logic [DEPTH*CHAR_W-1:0] line;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    full;
    logic                    err;

    modport master (
        output clr, push_valid, push_char, pop_valid,
        input  push_ready, pop_ready, line, count, empty, full, err
    );

    modport slave (
        input  clr, push_valid, push_char, pop_valid,
        output push_ready, pop_ready, line, count, empty, full, err
    );

endinterface

// File: rtl/char_line_buffer_slot.sv
// One character slot of the line buffer: a CHAR_W register that holds, loads
// from its newer (left) or older (right) neighbour, or loads a direct value.
module char_slot
    import morse_pkg::*;
#(
    parameter int                CHAR_W  = CHAR_W_DEF,
    parameter logic [CHAR_W-1:0] RST_VAL = CHAR_W'(BLANK_CHAR)
) (
    input  logic              clk,
    input  logic              rst,
    input  slot_sel_t         sel,
    input  logic [CHAR_W-1:0] left_char,
    input  logic [CHAR_W-1:0] right_char,
    input  logic [CHAR_W-1:0] load_char,
    output logic [CHAR_W-1:0] q
);

    // Slot register with four-way load mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            case (sel)
                SEL_LEFT:  q <= left_char;
                SEL_RIGHT: q <= right_char;
                SEL_VALUE: q <= load_char;
                SEL_HOLD:  q <= q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/char_line_buffer.sv
// Character line buffer for decoded Morse symbols; newest character in slot 0.
// Build option CHAR_LINE_BUFFER_SCROLL_EN: pushing into a full line scrolls out the oldest.
module char_line_buffer
    import morse_pkg::*;
#(
    parameter int                CHAR_W = CHAR_W_DEF,
    parameter int                DEPTH  = 8,
    parameter logic [CHAR_W-1:0] FILL   = CHAR_W'(BLANK_CHAR)
) (
    input logic               clk,
    input logic               rst,
    char_line_buffer_if.slave bus
);

    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT  = CNT_W'(0);

    op_t                     op_s;
    logic                    push_ready_s;
    logic                    err_nxt_s;
    logic [CNT_W-1:0]        count_nxt_s;
    logic [CHAR_W-1:0]       load_char_s;
    logic [DEPTH*CHAR_W-1:0] line_s;
    slot_sel_t               sel_s  [DEPTH];
    logic [CHAR_W-1:0]       slot_s [DEPTH];

    logic [CNT_W-1:0]        count_r;
    logic                    empty_r;
    logic                    full_r;
    logic                    err_r;

`ifdef CHAR_LINE_BUFFER_SCROLL_EN
    assign push_ready_s = 1'b1;
`else
    assign push_ready_s = ~full_r;
`endif

    // Decode the single operation applied this cycle (clr > replace > push > pop).
    always_comb begin
        op_s      = OP_NONE;
        err_nxt_s = 1'b0;
        if (bus.clr) begin
            op_s = OP_CLR;
        end else if (bus.push_valid && bus.pop_valid && !empty_r) begin
            op_s = OP_REPLACE;
        end else if (bus.push_valid) begin
            if (push_ready_s) begin
                op_s = OP_PUSH;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else if (bus.pop_valid) begin
            if (!empty_r) begin
                op_s = OP_POP;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            op_s = OP_NONE;
        end
    end

    // Next occupancy; a scrolling push into a full line keeps the count at DEPTH.
    always_comb begin
        count_nxt_s = count_r;
        case (op_s)
            OP_CLR:  count_nxt_s = ZERO_CNT;
            OP_PUSH: begin
                if (count_r != DEPTH_CNT) begin
                    count_nxt_s = count_r + ONE_CNT;
                end else begin
                    count_nxt_s = count_r;
                end
            end
            OP_POP:  count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
    end

    // Slot select per position, and the direct value (blank on clear, new char otherwise).
    always_comb begin
        load_char_s = (op_s == OP_CLR) ? FILL : bus.push_char;
        for (int k = 0; k < DEPTH; k++) begin
            sel_s[k] = slot_sel(op_s, (k == 0));
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic [CHAR_W-1:0] left_s;
        logic [CHAR_W-1:0] right_s;

        if (k == 0) begin : g_first
            assign left_s = FILL;
        end else begin : g_inner_l
            assign left_s = slot_s[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign right_s = FILL;
        end else begin : g_inner_r
            assign right_s = slot_s[k+1];
        end

        char_slot #(
            .CHAR_W  (CHAR_W),
            .RST_VAL (FILL)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .sel        (sel_s[k]),
            .left_char  (left_s),
            .right_char (right_s),
            .load_char  (load_char_s),
            .q          (slot_s[k])
        );
    end

    // Occupancy, flags and error pulse, all derived from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_CNT;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == ZERO_CNT);
            full_r  <= (count_nxt_s == DEPTH_CNT);
            err_r   <= err_nxt_s;
        end
    end

    // Flatten slots onto the display bus, slot 0 in the low bits.
    always_comb begin
        line_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            line_s[k*CHAR_W +: CHAR_W] = slot_s[k];
        end
    end

    assign bus.push_ready = push_ready_s;
    assign bus.pop_ready  = ~empty_r;
    assign bus.line       = line_s;
    assign bus.count      = count_r;
    assign bus.empty      = empty_r;
    assign bus.full       = full_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_char_line_buffer.sv
// Directed self-checking bench for char_line_buffer (DEPTH=8, CHAR_W=8, FILL=8'hFF).
module tb_char_line_buffer;

    localparam logic [63:0] ALL_FILL = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CHAR_LINE_BUFFER_SCROLL_EN
    localparam logic SCROLL = 1'b1;
`else
    localparam logic SCROLL = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    char_line_buffer_if #(.CHAR_W(8), .DEPTH(8)) bus ();

    char_line_buffer #(.CHAR_W(8), .DEPTH(8), .FILL(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of requests, then return to idle 1 time unit after the edge.
    task automatic cycle(input logic c, input logic pv, input logic [7:0] pc, input logic ppv);
        bus.clr        = c;
        bus.push_valid = pv;
        bus.push_char  = pc;
        bus.pop_valid  = ppv;
        @(posedge clk);
        #1;
        bus.clr        = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_char  = 8'h00;
        bus.pop_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.line !== ALL_FILL) begin errors++; $display("FAIL reset_line: got %h want %h", bus.line, ALL_FILL); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_flags: got e=%b f=%b err=%b want 1 0 0", bus.empty, bus.full, bus.err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        cycle(1'b0, 1'b1, 8'h41, 1'b0);
        cycle(1'b0, 1'b1, 8'h42, 1'b0);
        cycle(1'b0, 1'b1, 8'h43, 1'b0);
        checks++; if (bus.line !== 64'hFFFF_FFFF_FF41_4243) begin errors++; $display("FAIL push3_line: got %h want ffffffffff414243", bus.line); end
        checks++; if (bus.count !== 4'd3 || bus.empty !== 1'b0) begin errors++; $display("FAIL push3_count: got %0d e=%b want 3 0", bus.count, bus.empty); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (bus.line !== 64'hFFFF_FFFF_FFFF_4142) begin errors++; $display("FAIL pop_line: got %h want ffffffffffff4142", bus.line); end
        checks++; if (bus.count !== 4'd2 || bus.err !== 1'b0) begin errors++; $display("FAIL pop_count: got %0d err=%b want 2 0", bus.count, bus.err); end
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);
        checks++; if (bus.count !== 4'd3 || bus.line !== 64'hFFFF_FFFF_FF41_42FF) begin errors++; $display("FAIL push_fill_code: got %0d %h want 3 ffffffffff4142ff", bus.count, bus.line); end
    endtask

    task automatic test_mid_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.line !== ALL_FILL || bus.count !== 4'd0) begin errors++; $display("FAIL async_rst: got %h cnt=%0d want all ff cnt=0", bus.line, bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL async_rst_flags: got e=%b err=%b want 1 0", bus.empty, bus.err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        checks++; if (bus.line !== 64'h0102_0304_0506_0708 || bus.full !== 1'b1) begin errors++; $display("FAIL fill8: got %h full=%b want 0102030405060708 1", bus.line, bus.full); end
        checks++; if (bus.push_ready !== SCROLL) begin errors++; $display("FAIL full_push_ready: got %b want %b", bus.push_ready, SCROLL); end
        cycle(1'b0, 1'b1, 8'h09, 1'b0);
        if (SCROLL) begin
            checks++; if (bus.line !== 64'h0203_0405_0607_0809) begin errors++; $display("FAIL scroll_line: got %h want 0203040506070809", bus.line); end
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL scroll_err: got %b want 0", bus.err); end
        end else begin
            checks++; if (bus.line !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL reject_line: got %h want 0102030405060708", bus.line); end
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL reject_err: got %b want 1", bus.err); end
        end
        checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin errors++; $display("FAIL full_count: got %0d full=%b want 8 1", bus.count, bus.full); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL full_err_pulse: got %b want 0", bus.err); end
    endtask

    task automatic test_empty_pop();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.pop_ready !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL empty_pop_ready: got %b e=%b want 0 1", bus.pop_ready, bus.empty); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (bus.err !== 1'b1 || bus.count !== 4'd0 || bus.line !== ALL_FILL) begin errors++; $display("FAIL empty_pop: got err=%b cnt=%0d %h want 1 0 all ff", bus.err, bus.count, bus.line); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL empty_pop_pulse: got %b want 0", bus.err); end
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        checks++; if (bus.count !== 4'd1 || bus.err !== 1'b0 || bus.line !== 64'hFFFF_FFFF_FFFF_FF55) begin errors++; $display("FAIL empty_push_pop: got cnt=%0d err=%b %h want 1 0 ffffffffffffff55", bus.count, bus.err, bus.line); end
    endtask

    task automatic test_replace();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h41, 1'b0);
        cycle(1'b0, 1'b1, 8'h42, 1'b0);
        cycle(1'b0, 1'b1, 8'h43, 1'b0);
        cycle(1'b0, 1'b1, 8'h58, 1'b1);
        checks++; if (bus.line !== 64'hFFFF_FFFF_FF41_4258) begin errors++; $display("FAIL replace_line: got %h want ffffffffff414258", bus.line); end
        checks++; if (bus.count !== 4'd3 || bus.err !== 1'b0) begin errors++; $display("FAIL replace_count: got %0d err=%b want 3 0", bus.count, bus.err); end
    endtask

    task automatic test_clr();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        checks++; if (bus.count !== 4'd5 || bus.line !== 64'hFFFF_FF30_3132_3334) begin errors++; $display("FAIL pre_clr: got %0d %h want 5 ffffff3031323334", bus.count, bus.line); end
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        checks++; if (bus.line !== ALL_FILL || bus.count !== 4'd0) begin errors++; $display("FAIL clr_line: got %h cnt=%0d want all ff 0", bus.line, bus.count); end
        checks++; if (bus.err !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL clr_flags: got err=%b e=%b want 0 1", bus.err, bus.empty); end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.clr        = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_char  = 8'h00;
        bus.pop_valid  = 1'b0;
        test_reset();
        test_push_pop();
        test_mid_reset();
        test_full();
        test_empty_pop();
        test_replace();
        test_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
